alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Upstream control stage of the register-file/ALU datapath. Fetches fixed-format instructions
//  from an external synchronous program ROM, decodes them and drives the datapath controls:
//  register addresses, write enable, immediate-select/data, ALU opcode and carry-in.
//  Replaces the manual switch inputs of the datapath test harness with a programmed run.
// PARAMETERS
//  WIDTH   3  datapath word width (immediate and register width)
//  AWIDTH  2  register-file address width
//  PWIDTH  4  program counter / ROM address width (program length 2**PWIDTH)
//  IWIDTH  8+3*AWIDTH+WIDTH (=17)  instruction width, derived, do not override
// PORTS
//  CLK        in   1       clock, all state updates on rising edge
//  RST_N      in   1       asynchronous active-low reset
//  START      in   1       run request, sampled in IDLE only
//  STOP       in   1       abort request, sampled in FETCH/DECODE/EXEC
//  ROM_ADDR   out  PWIDTH  program ROM address (= PC)
//  ROM_DATA   in   IWIDTH  ROM word, valid one cycle after ROM_ADDR (sync ROM)
//  A_ADDR     out  AWIDTH  register-file read port A address
//  B_ADDR     out  AWIDTH  register-file read port B address
//  C_ADDR     out  AWIDTH  register-file write port address
//  C_WE       out  1       write enable, active-high, exactly one cycle per write
//  C_IN       out  1       1: write C_DIN immediate, 0: write ALU result
//  C_DIN      out  WIDTH   immediate write data
//  ALU_OP     out  4       ALU instruction code
//  ALU_CIN    out  1       ALU carry-in
//  CARRY_IN   in   1       ALU carry-out, sampled at end of EXEC
//  CARRY_FLAG out  1       last captured ALU carry
//  BUSY       out  1       high in FETCH/DECODE/EXEC
//  DONE       out  1       one-cycle pulse on normal completion
//  ILLEGAL    out  1       sticky: undefined opcode executed; cleared by START
// BEHAVIOUR
//  Instruction = {OP[3:0], AOP[3:0], DST, SA, SB (AWIDTH each), IMM (WIDTH)}, OP in MSBs.
//  OP: 0 NOP; 1 LDI (reg[DST]=IMM); 2 ALU (reg[DST]=alu(AOP,SA,SB), cin=0);
//      3 ALUC (same, cin=CARRY_FLAG); F HALT; others = NOP + set ILLEGAL.
//  Reset: state IDLE, PC=0, all outputs 0 (C_WE=0, BUSY=0, DONE=0, CARRY_FLAG=0, ILLEGAL=0).
//  FSM: IDLE -> FETCH -> DECODE -> EXEC -> FETCH | DONE -> IDLE.
//   IDLE: START=1 -> PC=0, ILLEGAL=0, CARRY_FLAG=0, go FETCH. Else hold.
//   FETCH: ROM_ADDR=PC presented; go DECODE.
//   DECODE: ROM_DATA valid; at edge register A_ADDR=SA, B_ADDR=SB, C_ADDR=DST, C_DIN=IMM,
//    ALU_OP=AOP, C_IN=(OP==1), ALU_CIN=(OP==3)&CARRY_FLAG, C_WE=(OP in 1..3); go EXEC.
//   EXEC: controls stable whole cycle; RAM writes mid-cycle. At edge: C_WE->0;
//    OP 2/3 -> CARRY_FLAG=CARRY_IN; undefined OP -> ILLEGAL=1;
//    HALT or PC==2**PWIDTH-1 -> DONE state (PC wraps to 0); else PC+1, go FETCH.
//   DONE: DONE=1 this cycle only, BUSY=0; go IDLE.
//  Latency: 3 cycles/instruction; C_WE high only in EXEC. HALT does not write.
//  Address/data outputs hold last values outside EXEC (no glitching required off-EXEC).
//  START while BUSY ignored. START in DONE ignored (accepted next cycle in IDLE).
//  STOP (FETCH/DECODE/EXEC) -> IDLE at next edge, no DONE pulse, PC held, C_WE->0.
//   STOP in DECODE: no write occurs. STOP in EXEC: write already in flight completes,
//   CARRY_FLAG still captured. STOP has priority over HALT/wrap.
//  RST_N low any time: immediate return to reset values; C_WE drops asynchronously.
//  PC arithmetic modulo 2**PWIDTH; no other arithmetic in this block.
// TESTING
//  1 Reset: RST_N=0 mid-EXEC -> C_WE=0, BUSY=0, PC=0 immediately, no further RAM write.
//  2 Prog {LDI r1,3; LDI r2,4; ALU AOP=5 r3=r1,r2; HALT}, START -> C_WE pulses at cycles
//    3,6,9 after START edge; C_IN=1,1,0; DONE pulse once; r3 via ALU = 7, CARRY_FLAG=0.
//  3 LDI r1,7; LDI r2,7; ALU add r0; ALUC add r3 -> first ALU captures CARRY_FLAG=1,
//    ALUC drives ALU_CIN=1 during its EXEC.
//  4 Program of 16 NOPs, no HALT -> PC 0..15, wraps to 0, DONE after 48 cycles, C_WE never 1.
//  5 OP=4'h7 at PC 2 -> ILLEGAL=1 sticky through DONE, cleared on next START.
//  6 STOP in DECODE of an LDI -> no C_WE pulse, BUSY=0 next cycle, DONE stays 0; START while
//    BUSY ignored (PC not reset).

Source files
------------

// File: rtl/alu_sequencer.sv
// Control stage for the register-file/ALU datapath: fetches program ROM words,
// decodes them and sequences register writes, ALU opcode and carry handling.
module alu_sequencer #(
  parameter  int WIDTH  = 3,
  parameter  int AWIDTH = 2,
  parameter  int PWIDTH = 4,
  localparam int IWIDTH = 8 + 3 * AWIDTH + WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic [PWIDTH-1:0] rom_addr,
  input  logic [IWIDTH-1:0] rom_data,
  output logic [AWIDTH-1:0] a_addr,
  output logic [AWIDTH-1:0] b_addr,
  output logic [AWIDTH-1:0] c_addr,
  output logic              c_we,
  output logic              c_in,
  output logic [WIDTH-1:0]  c_din,
  output logic [3:0]        alu_op,
  output logic              alu_cin,
  input  logic              carry_in,
  output logic              carry_flag,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [3:0]        aop;
    logic [AWIDTH-1:0] dst;
    logic [AWIDTH-1:0] sa;
    logic [AWIDTH-1:0] sb;
    logic [WIDTH-1:0]  imm;
  } instr_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ALU  = 4'h2;
  localparam logic [3:0] OP_ALUC = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hf;

  state_t            state;
  logic [PWIDTH-1:0] pc;
  logic [3:0]        op_q;
  instr_t            ins;

  logic dec_ldi;
  logic dec_alu;
  logic dec_aluc;
  logic ex_alu;
  logic ex_bad;
  logic ex_halt;
  logic pc_last;

  assign ins      = rom_data;
  assign rom_addr = pc;

  assign dec_ldi  = (ins.op == OP_LDI);
  assign dec_alu  = (ins.op == OP_ALU);
  assign dec_aluc = (ins.op == OP_ALUC);

  assign ex_alu  = (op_q == OP_ALU) | (op_q == OP_ALUC);
  assign ex_halt = (op_q == OP_HALT);
  assign ex_bad  = ~(ex_alu | ex_halt
                   | (op_q == OP_NOP)
                   | (op_q == OP_LDI));
  assign pc_last = (pc == {PWIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      op_q       <= '0;
      a_addr     <= '0;
      b_addr     <= '0;
      c_addr     <= '0;
      c_we       <= 1'b0;
      c_in       <= 1'b0;
      c_din      <= '0;
      alu_op     <= '0;
      alu_cin    <= 1'b0;
      carry_flag <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            pc         <= '0;
            illegal    <= 1'b0;
            carry_flag <= 1'b0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            a_addr  <= ins.sa;
            b_addr  <= ins.sb;
            c_addr  <= ins.dst;
            c_din   <= ins.imm;
            alu_op  <= ins.aop;
            c_in    <= dec_ldi;
            alu_cin <= dec_aluc & carry_flag;
            c_we    <= dec_ldi | dec_alu | dec_aluc;
            op_q    <= ins.op;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          c_we <= 1'b0;
          unique case (1'b1)
            ex_alu:  carry_flag <= carry_in;
            ex_bad:  illegal    <= 1'b1;
            default: ;
          endcase
          // stop wins over halt/wrap and leaves pc on this instruction
          if (stop) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            pc <= pc + 1'b1;
            if (ex_halt | pc_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
